// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the alarm countdown timer: FSM encodings and sizing constants.
package alarm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam int CLK_HZ_40M  = 40_000_000;
    localparam int TIMER_WIDTH = 4;
    // Prescaler counter is sized to hold CLK_HZ_40M - 1.
    localparam int PRESC_W     = 26;

endpackage

// File: rtl/alarm_timer_sec_prescaler.sv
// Seconds prescaler: emits a one-cycle tick every CLK_HZ (or DEBUG_DIV in debug mode) cycles.
module alarm_timer_sec_prescaler
    import alarm_timer_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_40M,
    parameter int DEBUG_DIV = 4_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic debug_on,
    output logic tick
);

    logic [PRESC_W-1:0] count;
    logic [PRESC_W-1:0] term;
    logic               debug_q;
    logic               debug_change;

    assign debug_change = (debug_on != debug_q);
    assign term         = debug_q ? PRESC_W'(DEBUG_DIV - 1) : PRESC_W'(CLK_HZ - 1);
    // A mode change or a load restarts the second, so the would-be wrap is suppressed.
    assign tick         = (count == term) && !clear && !debug_change && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            debug_q <= debug_on;
        end else begin
            debug_q <= debug_on;
            if (clear || debug_change || (count == term)) begin
                count <= '0;
            end else begin
                count <= count + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_timer.sv
// Programmable seconds countdown for the alarm FSM, with one-cycle expiry pulse and display feed.
module alarm_timer
    import alarm_timer_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_40M,
    parameter int DEBUG_DIV = 4_000,
    parameter int WIDTH     = TIMER_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic [WIDTH-1:0] value,
    input  logic             debug_on,
    output logic             expired,
    output logic             busy,
    output logic [WIDTH-1:0] time_left,
    output logic             sec_tick,
    output state_t           fsm_state
);

    // load_start is a fire-and-forget pulse: no ready, value is sampled only in that cycle,
    // and a load is always accepted, overriding any countdown in progress.

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] next_time;
    logic             next_busy;
    logic             tick;

    alarm_timer_sec_prescaler #(
        .CLK_HZ    (CLK_HZ),
        .DEBUG_DIV (DEBUG_DIV)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .clear    (load_start),
        .debug_on (debug_on),
        .tick     (tick)
    );

    always_comb begin
        next_state = state;
        next_time  = time_left;
        next_busy  = busy;
        if (load_start) begin
            // A load beats a coincident final tick, so a restart never expires.
            if (value != '0) begin
                next_state = COUNT;
                next_time  = value;
                next_busy  = 1'b1;
            end else begin
                next_state = EXPIRE;
                next_time  = '0;
                next_busy  = 1'b0;
            end
        end else begin
            case (state)
                COUNT: begin
                    if (tick) begin
                        if (time_left > WIDTH'(1)) begin
                            next_time = time_left - WIDTH'(1);
                        end else begin
                            next_state = EXPIRE;
                            next_time  = '0;
                            next_busy  = 1'b0;
                        end
                    end
                end
                EXPIRE: begin
                    next_state = IDLE;
                    next_time  = '0;
                    next_busy  = 1'b0;
                end
                default: begin
                    next_state = IDLE;
                    next_time  = '0;
                    next_busy  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            time_left <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            state     <= next_state;
            time_left <= next_time;
            busy      <= next_busy;
            expired   <= (next_state == EXPIRE);
            sec_tick  <= tick;
        end
    end

    assign fsm_state = state;

endmodule
